pic_mem_arbiter: RTL and testbench
==================================

PIC_MEM_ARBITER -- requirements
Module: pic_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, pic_mem port-2 word address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width; BE_W = DATA_W/8.
REQ-003 SHALL have parameter BURST_MAX, default 16, max consecutive locked grants to one master (range 1..255).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk_clk (input, 1, rising-edge clock) and reset_reset (input, 1, async active-high reset).
REQ-005 SHALL provide, per master N in {0,1}: mN_req in 1 (access request); mN_write in 1 (1=write); mN_lock in 1 (keep ownership after this access); mN_address in ADDR_W; mN_writedata in DATA_W; mN_byteenable in BE_W.
REQ-006 SHALL provide, per master N: mN_gnt out 1 (request accepted this cycle); mN_rvalid out 1 (read data valid); mN_readdata out DATA_W.
REQ-007 SHALL drive the memory port: mem_address out ADDR_W; mem_chipselect out 1; mem_clken out 1; mem_write out 1; mem_writedata out DATA_W; mem_byteenable out BE_W; mem_readdata in DATA_W (1-cycle read latency).

Function
REQ-008 SHALL implement FSM states IDLE, OWN0, OWN1; OWNn means master n holds a lock.
REQ-009 In IDLE, single requester SHALL be granted combinationally in the same cycle; both requesting SHALL grant the master not granted last (round-robin pointer, reset value selects m0 first).
REQ-010 At most one mN_gnt SHALL be high per cycle; gnt only when mN_req=1.
REQ-011 Granted access with mN_lock=1 SHALL enter/stay OWNn; in OWNn only master n is granted, other master waits.
REQ-012 OWNn SHALL return to IDLE when owner is granted with lock=0, when owner drops req, or when lock count reaches BURST_MAX; pointer then favours the other master.
REQ-013 Lock counter SHALL count grants in OWNn, clear on exit; at BURST_MAX the BURST_MAX-th grant is given and ownership released.
REQ-014 Accepted access in cycle t SHALL appear on mem_* in t+1 with mem_chipselect=1 (registered); mem_chipselect=0 in cycles with no grant.
REQ-015 For a read granted at t, mN_rvalid SHALL be high in t+2 only, with mN_readdata = mem_readdata of t+2; writes produce no rvalid.
REQ-016 Throughput SHALL be one access per cycle; back-to-back reads from alternating masters each return in order to the correct master.
REQ-017 mN_readdata SHALL be mem_readdata passed through (both masters see it); only rvalid is steered.
REQ-018 mem_clken SHALL be 1 in every cycle after reset release.

Reset
REQ-019 Reset SHALL force: state IDLE, pointer m0, lock counter 0, mem_chipselect/mem_write/mem_clken 0, mem_address/writedata/byteenable 0, all rvalid 0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight reads (no rvalid after release); mN_gnt SHALL be 0 while reset is high.

Configuration
REQ-021 With PIC_MEM_ARB_PRIO_EN defined, IDLE arbitration SHALL be fixed-priority m0 over m1 (pointer unused); locks and BURST_MAX still apply.
REQ-022 Without PIC_MEM_ARB_PRIO_EN, IDLE arbitration SHALL be round-robin per REQ-009.

Structure
REQ-023 A shared package SHALL hold the FSM state enum (IDLE, OWN0, OWN1) and default ADDR_W/DATA_W/BURST_MAX constants.
REQ-024 Single module; no sub-module (grant logic inline).

Verification
REQ-025 Single read: m0 read addr 0x123 at t, memory returns 0xBEEF -> mem_chipselect at t+1 addr 0x123, m0_rvalid at t+2 data 0xBEEF, m1_rvalid 0.
REQ-026 Contention: m0,m1 request continuously, no lock -> grants alternate m0,m1,m0,m1; with PIC_MEM_ARB_PRIO_EN -> m0 every cycle.
REQ-027 Lock: m1 locks with continuous req while m0 requests, BURST_MAX=4 -> exactly 4 m1 grants, then m0 granted.
REQ-028 Write: m0 write addr 0x010 data 0x5A5A be 2'b01 -> t+1 mem_write=1, mem_byteenable 2'b01, no rvalid.
REQ-029 Reset at t+1 after read grant -> no rvalid after release, all mem_* 0 during reset, first post-reset contention grants m0.

Source files
------------

// File: rtl/pic_mem_arbiter_pkg.sv
// Shared state encoding and default sizing for the pic_mem port-2 arbiter.
package pic_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BURST_MAX = 16;
    localparam int LOCK_CNT_W    = 8;

endpackage

// File: rtl/pic_mem_arbiter.sv
// Two-master arbiter for pic_mem port 2: same-cycle grant, registered memory command,
// read-valid steered back to the issuing master. PIC_MEM_ARB_PRIO_EN selects m0-over-m1 priority.
module pic_mem_arbiter
    import pic_mem_arbiter_pkg::*;
#(
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int BURST_MAX = DEF_BURST_MAX,
    localparam int BE_W      = DATA_W / 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,

    input  logic              m0_req,
    input  logic              m0_write,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_readdata,

    input  logic              m1_req,
    input  logic              m1_write,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_readdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [LOCK_CNT_W-1:0] BURST_LIM = LOCK_CNT_W'(BURST_MAX);

    arb_state_e            state_q, state_d;
    logic                  ptr_q, ptr_d;          // 1 = m1 wins the next IDLE tie
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_inc;

    logic                  gnt0, gnt1, any_gnt, sel_lock;

    logic                  cs_q, cs_d;
    logic                  wr_q, wr_d;
    logic                  src_q, src_d;          // master that issued the command stage
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic                  clken_q;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef PIC_MEM_ARB_PRIO_EN
                if (m0_req) begin
                    gnt0 = 1'b1;
                end else if (m1_req) begin
                    gnt1 = 1'b1;
                end
`else
                if (m0_req && (!m1_req || !ptr_q)) begin
                    gnt0 = 1'b1;
                end else if (m1_req) begin
                    gnt1 = 1'b1;
                end
`endif
            end
            OWN0:    gnt0 = m0_req;
            OWN1:    gnt1 = m1_req;
            default: ;
        endcase
        // Grants are combinational, so they must be masked explicitly while reset is held.
        if (reset_reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign any_gnt      = gnt0 | gnt1;
    assign sel_lock     = gnt1 ? m1_lock : m0_lock;
    assign lock_cnt_inc = lock_cnt_q + LOCK_CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (any_gnt) begin
            ptr_d = gnt0;
            // The grant that reaches BURST_MAX is still served, then ownership is dropped.
            if (sel_lock && (lock_cnt_inc < BURST_LIM)) begin
                state_d    = gnt1 ? OWN1 : OWN0;
                lock_cnt_d = lock_cnt_inc;
            end else begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        end else if (state_q != IDLE) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end
    end

    always_comb begin
        cs_d    = any_gnt;
        wr_d    = 1'b0;
        src_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
        if (gnt0) begin
            wr_d    = m0_write;
            addr_d  = m0_address;
            wdata_d = m0_writedata;
            be_d    = m0_byteenable;
        end else if (gnt1) begin
            wr_d    = m1_write;
            src_d   = 1'b1;
            addr_d  = m1_address;
            wdata_d = m1_writedata;
            be_d    = m1_byteenable;
        end
        rvalid0_d = cs_q && !wr_q && !src_q;
        rvalid1_d = cs_q && !wr_q &&  src_q;
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            lock_cnt_q <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            src_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            clken_q    <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            clken_q    <= 1'b1;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign m0_gnt         = gnt0;
    assign m1_gnt         = gnt1;
    assign m0_rvalid      = rvalid0_q;
    assign m1_rvalid      = rvalid1_q;
    assign m0_readdata    = mem_readdata;
    assign m1_readdata    = mem_readdata;

    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_clken      = clken_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = wdata_q;
    assign mem_byteenable = be_q;

endmodule

// File: tb/tb_pic_mem_arbiter.sv
// Randomized self-checking bench for pic_mem_arbiter against a transaction-level model
// (honours PIC_MEM_ARB_PRIO_EN the same way the design does).
module tb_pic_mem_arbiter;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int BE_W      = DATA_W / 8;
    localparam int BURST_MAX = 4;

    typedef struct packed {
        logic              req;
        logic              write;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mst_t;

    typedef struct packed {
        logic              valid;
        logic              master;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    localparam mst_t NO_REQ = '0;

    logic              clk;
    logic              reset_reset;
    logic              m0_req, m0_write, m0_lock, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_address;
    logic [DATA_W-1:0] m0_writedata, m0_readdata;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m1_req, m1_write, m1_lock, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_address;
    logic [DATA_W-1:0] m1_writedata, m1_readdata;
    logic [BE_W-1:0]   m1_byteenable;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_clken, mem_write;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic [BE_W-1:0]   mem_byteenable;

    pic_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (reset_reset),
        .m0_req         (m0_req),
        .m0_write       (m0_write),
        .m0_lock        (m0_lock),
        .m0_address     (m0_address),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_readdata    (m0_readdata),
        .m1_req         (m1_req),
        .m1_write       (m1_write),
        .m1_lock        (m1_lock),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_readdata    (m1_readdata),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    // Memory device with one-cycle read latency, driven only by the DUT's memory port.
    logic [DATA_W-1:0] dev_mem [2**ADDR_W];
    logic [DATA_W-1:0] dev_w;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                dev_w = dev_mem[mem_address];
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) dev_w[b*8 +: 8] = mem_writedata[b*8 +: 8];
                dev_mem[mem_address] <= dev_w;
            end else begin
                mem_readdata <= dev_mem[mem_address];
            end
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    int   owner;
    int   burst;
    int   last;
    txn_t p1, p2;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < BE_W; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic mst_t mk(input logic req, input logic write, input logic lock,
                                input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input logic [BE_W-1:0] be);
        mst_t m;
        m.req = req; m.write = write; m.lock = lock;
        m.addr = a; m.wdata = d; m.be = be;
        return m;
    endfunction

    function automatic mst_t rnd_mst();
        mst_t m;
        m.req   = ($urandom_range(0, 9) < 7);
        m.write = 1'($urandom_range(0, 1));
        m.lock  = ($urandom_range(0, 3) == 0);
        m.addr  = ADDR_W'($urandom_range(0, 15));
        m.wdata = DATA_W'($urandom);
        m.be    = BE_W'($urandom_range(0, 3));
        return m;
    endfunction

    task automatic drive(input mst_t s0, input mst_t s1);
        m0_req = s0.req; m0_write = s0.write; m0_lock = s0.lock;
        m0_address = s0.addr; m0_writedata = s0.wdata; m0_byteenable = s0.be;
        m1_req = s1.req; m1_write = s1.write; m1_lock = s1.lock;
        m1_address = s1.addr; m1_writedata = s1.wdata; m1_byteenable = s1.be;
    endtask

    // One clock cycle: drive at negedge, check outputs against the model, advance the model.
    task automatic cycle(input mst_t s0, input mst_t s1, output logic g0, output logic g1);
        int   g;
        mst_t src;
        txn_t cur;
        @(negedge clk);
        drive(s0, s1);
        #1;
        g = -1;
        if (owner >= 0) begin
            if ((owner == 0 && s0.req) || (owner == 1 && s1.req)) g = owner;
        end else if (s0.req && s1.req) begin
`ifdef PIC_MEM_ARB_PRIO_EN
            g = 0;
`else
            g = 1 - last;
`endif
        end else if (s0.req) begin
            g = 0;
        end else if (s1.req) begin
            g = 1;
        end
        g0 = m0_gnt;
        g1 = m1_gnt;
        check("m0_gnt", 32'(m0_gnt), 32'(g == 0));
        check("m1_gnt", 32'(m1_gnt), 32'(g == 1));
        check("mem_clken", 32'(mem_clken), 32'd1);
        check("mem_chipselect", 32'(mem_chipselect), 32'(p1.valid));
        if (p1.valid) begin
            check("mem_write", 32'(mem_write), 32'(p1.write));
            check("mem_address", 32'(mem_address), 32'(p1.addr));
            if (p1.write) begin
                check("mem_writedata", 32'(mem_writedata), 32'(p1.wdata));
                check("mem_byteenable", 32'(mem_byteenable), 32'(p1.be));
            end
        end
        check("m0_rvalid", 32'(m0_rvalid), 32'(p2.valid && !p2.write && !p2.master));
        check("m1_rvalid", 32'(m1_rvalid), 32'(p2.valid && !p2.write &&  p2.master));
        if (p2.valid && !p2.write) begin
            check("m0_readdata", 32'(m0_readdata), 32'(p2.rdata));
            check("m1_readdata", 32'(m1_readdata), 32'(p2.rdata));
        end

        cur = '0;
        if (g >= 0) begin
            src         = (g == 1) ? s1 : s0;
            cur.valid   = 1'b1;
            cur.master  = (g == 1);
            cur.write   = src.write;
            cur.addr    = src.addr;
            cur.wdata   = src.wdata;
            cur.be      = src.be;
            if (src.write) ref_mem[src.addr] = merge(ref_mem[src.addr], src.wdata, src.be);
            else           cur.rdata = ref_mem[src.addr];
            burst = (owner == g) ? burst + 1 : 1;
            last  = g;
            if (src.lock && burst < BURST_MAX) begin
                owner = g;
            end else begin
                owner = -1;
                burst = 0;
            end
        end else if (owner >= 0) begin
            owner = -1;
            burst = 0;
        end
        p2 = p1;
        p1 = cur;
    endtask

    task automatic apply_reset(input int ncyc);
        @(negedge clk);
        reset_reset = 1'b1;
        drive(mk(1'b1, 1'b0, 1'b0, '0, '0, '0), mk(1'b1, 1'b0, 1'b0, '0, '0, '0));
        #1;
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        check("rst_chipselect", 32'(mem_chipselect), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_clken", 32'(mem_clken), 32'd0);
        check("rst_address", 32'(mem_address), 32'd0);
        check("rst_writedata", 32'(mem_writedata), 32'd0);
        check("rst_byteenable", 32'(mem_byteenable), 32'd0);
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        repeat (ncyc) @(negedge clk);
        #1;
        check("rst_hold_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_hold_chipselect", 32'(mem_chipselect), 32'd0);
        check("rst_hold_m0_rvalid", 32'(m0_rvalid), 32'd0);
        reset_reset = 1'b0;
        drive(NO_REQ, NO_REQ);
        owner = -1;
        burst = 0;
        last  = 1;
        p1    = '0;
        p2    = '0;
    endtask

    initial begin
        logic g0, g1;
        int   cnt1;
        mst_t s0, s1;
        clk         = 1'b0;
        reset_reset = 1'b1;
        n_checks    = 0;
        n_errors    = 0;
        drive(NO_REQ, NO_REQ);
        apply_reset(2);

        // Fill the random-traffic address window through the DUT so both memories agree.
        for (int i = 0; i < 16; i++)
            cycle(mk(1'b1, 1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom), 2'b11), NO_REQ, g0, g1);
        cycle(NO_REQ, mk(1'b1, 1'b1, 1'b0, 12'h123, 16'hBEEF, 2'b11), g0, g1);

        // Single read of 0xBEEF
        cycle(mk(1'b1, 1'b0, 1'b0, 12'h123, '0, '0), NO_REQ, g0, g1);
        check("sr_gnt", 32'(g0), 32'd1);
        cycle(NO_REQ, NO_REQ, g0, g1);
        check("sr_cs", 32'(mem_chipselect), 32'd1);
        check("sr_addr", 32'(mem_address), 32'h123);
        check("sr_rvalid_early", 32'(m0_rvalid), 32'd0);
        cycle(NO_REQ, NO_REQ, g0, g1);
        check("sr_rvalid", 32'(m0_rvalid), 32'd1);
        check("sr_data", 32'(m0_readdata), 32'hBEEF);
        check("sr_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // Continuous contention, no lock; m0 was granted last
        for (int i = 0; i < 6; i++) begin
            cycle(mk(1'b1, 1'b0, 1'b0, ADDR_W'(i), '0, '0),
                  mk(1'b1, 1'b0, 1'b0, ADDR_W'(i + 8), '0, '0), g0, g1);
`ifdef PIC_MEM_ARB_PRIO_EN
            check("ct_m0_every", 32'(g0), 32'd1);
`else
            check("ct_alternate_m1", 32'(g1), 32'(i % 2 == 0));
`endif
        end

        // Locked burst by m1 while m0 keeps requesting
        cnt1 = 0;
        cycle(NO_REQ, mk(1'b1, 1'b0, 1'b1, 12'd3, '0, '0), g0, g1);
        cnt1 += int'(g1);
        for (int i = 0; i < 3; i++) begin
            cycle(mk(1'b1, 1'b0, 1'b0, 12'd1, '0, '0), mk(1'b1, 1'b0, 1'b1, 12'd3, '0, '0), g0, g1);
            cnt1 += int'(g1);
        end
        check("lock_m1_grants", 32'(cnt1), 32'd4);
        cycle(mk(1'b1, 1'b0, 1'b0, 12'd1, '0, '0), mk(1'b1, 1'b0, 1'b1, 12'd3, '0, '0), g0, g1);
        check("lock_release_m0", 32'(g0), 32'd1);
        cycle(NO_REQ, NO_REQ, g0, g1);
        cycle(NO_REQ, NO_REQ, g0, g1);

        // Byte-masked write
        cycle(mk(1'b1, 1'b1, 1'b0, 12'h010, 16'h5A5A, 2'b01), NO_REQ, g0, g1);
        check("wr_gnt", 32'(g0), 32'd1);
        cycle(NO_REQ, NO_REQ, g0, g1);
        check("wr_mem_write", 32'(mem_write), 32'd1);
        check("wr_byteenable", 32'(mem_byteenable), 32'h1);
        check("wr_address", 32'(mem_address), 32'h010);
        check("wr_writedata", 32'(mem_writedata), 32'h5A5A);
        cycle(NO_REQ, NO_REQ, g0, g1);
        check("wr_no_rvalid0", 32'(m0_rvalid), 32'd0);
        check("wr_no_rvalid1", 32'(m1_rvalid), 32'd0);

        // Reset one cycle after a read grant discards it
        cycle(mk(1'b1, 1'b0, 1'b0, 12'd5, '0, '0), NO_REQ, g0, g1);
        apply_reset(2);
        for (int i = 0; i < 3; i++) begin
            cycle(NO_REQ, NO_REQ, g0, g1);
            check("post_rst_rvalid0", 32'(m0_rvalid), 32'd0);
        end
        cycle(mk(1'b1, 1'b0, 1'b0, 12'd2, '0, '0), mk(1'b1, 1'b0, 1'b0, 12'd4, '0, '0), g0, g1);
        check("post_rst_first_m0", 32'(g0), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            s0 = rnd_mst();
            s1 = rnd_mst();
            cycle(s0, s1, g0, g1);
        end
        cycle(NO_REQ, NO_REQ, g0, g1);
        cycle(NO_REQ, NO_REQ, g0, g1);
        cycle(NO_REQ, NO_REQ, g0, g1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
